// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding and register-index width.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // True when a source operand is read and names the register the load will write.
  function automatic logic src_hits(input logic             use_src,
                                    input logic [REG_W-1:0] src_reg,
                                    input logic [REG_W-1:0] dst_reg);
    return use_src & (src_reg == dst_reg);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic             at_max_s;

  assign at_max_s = (count_r == {CNT_W{1'b1}});
  assign count    = count_r;

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squashes, memory-busy freeze,
// plus saturating stall and flush counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_readReg1,
  input  logic [REG_W-1:0] id_readReg2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_writeReg,
  input  logic             ex_branchTaken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state_r;
  state_t next_state_s;
  logic   load_use_s;
  logic   squash_s;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use_s = ex_memRead & (ex_writeReg != {REG_W{1'b0}}) &
                      (src_hits(id_useRs1, id_readReg1, ex_writeReg) |
                       src_hits(id_useRs2, id_readReg2, ex_writeReg));

  // State register; reset parks the controller in INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and buffer controls; MEM_WAIT behaves like RUN once memory releases.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    squash_s     = 1'b0;
    next_state_s = state_r;
    case (state_r)
      INIT: begin
        pc_write     = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        next_state_s = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          next_state_s = MEM_WAIT;
        end else if (ex_branchTaken) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          squash_s     = 1'b1;
          next_state_s = RUN;
        end else if (load_use_s) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_flush   = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        pc_write     = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        next_state_s = INIT;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (squash_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second 4-bit-counter instance covers saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_readReg1;
  logic [4:0] id_readReg2;
  logic       id_useRs1;
  logic       id_useRs2;
  logic       ex_memRead;
  logic [4:0] ex_writeReg;
  logic       ex_branchTaken;
  logic       mem_busy;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush, s_exmem_write;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int vec_cnt;
  int err_cnt;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_writeReg(ex_writeReg),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_write(s_idex_write), .idex_flush(s_idex_flush), .exmem_write(s_exmem_write),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Packed controls {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}.
  task automatic check_ctl(input string tag, input logic [5:0] exp);
    check(tag, 32'({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}), 32'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b0;
    id_readReg1 = 5'd0; id_readReg2 = 5'd0;
    id_useRs1 = 1'b0; id_useRs2 = 1'b0;
    ex_memRead = 1'b0; ex_writeReg = 5'd0;
    ex_branchTaken = 1'b0; mem_busy = 1'b0;

    // Held in reset for three edges.
    repeat (3) cyc();
    check_ctl("reset_ctl", 6'b011111);
    check("reset_stall", stall_cnt, 32'd0);
    check("reset_flush", flush_cnt, 32'd0);

    // Release: one INIT cycle, then RUN.
    rst = 1'b1;
    #1;
    check_ctl("init_ctl", 6'b011111);
    cyc();
    check_ctl("run_ctl", 6'b111100);
    check("init_stall", stall_cnt, 32'd1);

    // Load-use on rs2 costs one bubble.
    ex_memRead = 1'b1; ex_writeReg = 5'd5; id_readReg2 = 5'd5; id_useRs2 = 1'b1;
    #1;
    check_ctl("lu_ctl", 6'b001101);
    cyc();
    check("lu_stall", stall_cnt, 32'd2);
    ex_memRead = 1'b0;
    #1;
    check_ctl("lu_clear_ctl", 6'b111100);

    // Load to x0 never stalls.
    ex_memRead = 1'b1; ex_writeReg = 5'd0; id_readReg1 = 5'd0; id_useRs1 = 1'b1;
    id_readReg2 = 5'd0; id_useRs2 = 1'b1;
    #1;
    check_ctl("x0_ctl", 6'b111100);
    cyc();
    // Matching register not actually read.
    ex_writeReg = 5'd7; id_readReg1 = 5'd7; id_useRs1 = 1'b0; id_readReg2 = 5'd3; id_useRs2 = 1'b1;
    #1;
    check_ctl("nouse_ctl", 6'b111100);
    cyc();
    check("nostall_cnt", stall_cnt, 32'd2);
    // Same register, now read via rs1: stall.
    id_useRs1 = 1'b1;
    #1;
    check("rs1_lu_pc", 32'(pc_write), 32'd0);
    cyc();
    check("rs1_lu_stall", stall_cnt, 32'd3);

    // Branch wins over the still-present load-use.
    ex_branchTaken = 1'b1;
    #1;
    check_ctl("br_lu_ctl", 6'b111111);
    cyc();
    check("br_flush", flush_cnt, 32'd1);
    check("br_stall", stall_cnt, 32'd3);

    // Memory busy for four cycles with the branch held.
    ex_memRead = 1'b0;
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_ctl($sformatf("busy_ctl%0d", i), 6'b000000);
      cyc();
    end
    check("busy_stall", stall_cnt, 32'd7);
    check("busy_flush", flush_cnt, 32'd1);
    mem_busy = 1'b0;
    #1;
    check_ctl("release_ctl", 6'b111111);
    cyc();
    check("release_flush", flush_cnt, 32'd2);
    check("release_stall", stall_cnt, 32'd7);
    ex_branchTaken = 1'b0;
    #1;
    check_ctl("after_release_ctl", 6'b111100);
    cyc();
    check("sat_pre", 32'(s_stall_cnt), 32'd7);

    // Twenty busy cycles: wide counter keeps counting, 4-bit one saturates.
    mem_busy = 1'b1;
    repeat (20) cyc();
    check("wide_stall", stall_cnt, 32'd27);
    check("sat_stall", 32'(s_stall_cnt), 32'd15);
    check("sat_flush", 32'(s_flush_cnt), 32'd2);

    // Reset mid-MEM_WAIT: immediate INIT, counters cleared.
    #3;
    rst = 1'b0;
    #1;
    check_ctl("rst_wait_ctl", 6'b011111);
    check("rst_wait_stall", stall_cnt, 32'd0);
    check("rst_wait_flush", flush_cnt, 32'd0);
    check("rst_wait_sat", 32'(s_stall_cnt), 32'd0);
    cyc();
    mem_busy = 1'b0;
    rst = 1'b1;
    #1;
    check_ctl("reinit_ctl", 6'b011111);
    cyc();
    check_ctl("rerun_ctl", 6'b111100);
    check("rerun_stall", stall_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that consumes the ID/EX buffer outputs and drives the write-enable and flush inputs of the PC and pipeline buffers. It detects load-use hazards, resolves taken-branch squashes and freezes the pipeline while data memory is busy. It also maintains saturating stall/flush performance counters. The block sits beside the ID stage, reading the IF/ID fields, the ID/EX outputs, EX branch resolution and the data-memory busy flag.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- id_readReg1  in  5  rs1 of the instruction currently in IF/ID
- id_readReg2  in  5  rs2 of the instruction currently in IF/ID
- id_useRs1  in  1  IF/ID instruction reads rs1
- id_useRs2  in  1  IF/ID instruction reads rs2
- ex_memRead  in  1  memRead_actual from the ID/EX buffer
- ex_writeReg  in  5  writeReg_actual from the ID/EX buffer
- ex_branchTaken  in  1  branch in EX resolved taken this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID buffer load enable
- ifid_flush  out  1  IF/ID loads a bubble (all zero)
- idex_write  out  1  ID/EX buffer load enable
- idex_flush  out  1  ID/EX loads a bubble (control fields zero)
- exmem_write  out  1  EX/MEM and MEM/WB load enable
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  taken-branch squash events

## Operation
- States: INIT, RUN, MEM_WAIT; state and counters registered, control outputs combinational from state and inputs.
- load_use = ex_memRead & ex_writeReg!=0 & ((id_useRs1 & id_readReg1==ex_writeReg) | (id_useRs2 & id_readReg2==ex_writeReg)).
- INIT: pc_write=0, ifid_flush=1, idex_flush=1, all *_write=1 except pc_write; next RUN unconditionally.
- RUN, priority mem_busy > ex_branchTaken > load_use:
  - mem_busy: pc_write=ifid_write=idex_write=exmem_write=0, no flush; next MEM_WAIT.
  - ex_branchTaken: all writes 1, ifid_flush=1, idex_flush=1; flush_cnt+1; stay RUN.
  - load_use: pc_write=0, ifid_write=0, idex_write=1, idex_flush=1 (one bubble); stay RUN.
  - none: all writes 1, no flush.
- MEM_WAIT: while mem_busy, all writes 0; on mem_busy=0 outputs equal RUN evaluation of the same cycle and next state RUN. A branch or load-use present during the wait is therefore handled in the release cycle, not lost.
- Flush overrides write on the same buffer: a flushed buffer loads zeros.
- Counters: stall_cnt +1 every cycle pc_write=0 (INIT included); saturate at all-ones, never wrap.

## Timing
- Reset (rst=0, asynchronous): state=INIT, stall_cnt=0, flush_cnt=0; while in reset outputs are pc_write=0, ifid_write=1, idex_write=1, exmem_write=1, ifid_flush=1, idex_flush=1.
- First edge after rst rises: INIT→RUN; INIT lasts exactly one cycle.
- Control outputs: zero latency (same cycle as inputs). Counters update on the edge ending the qualifying cycle.
- Load-use costs exactly 1 bubble: after the edge the load is in EX/MEM, ex_memRead drops to 0, hazard clears.
- Taken branch costs 2 squashed slots in one cycle.
- Reset asserted mid-MEM_WAIT or mid-stall: immediate return to INIT, counters cleared.
- ex_writeReg=0 never causes a stall.

## Structure
- Shared package `pipeline_pkg`: state enum (INIT, RUN, MEM_WAIT) and the register-index width constant (5).
- Optional sub-module `sat_counter` (CNT_W, inc, count), instantiated twice; otherwise flat.

## Test plan
- Reset release: rst low 3 cycles then high -> 1 cycle INIT (pc_write=0, both flushes=1), then RUN with all writes 1; stall_cnt=1.
- Load-use: ex_memRead=1, ex_writeReg=5, id_readReg2=5, id_useRs2=1 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle with ex_memRead=0 all writes 1.
- No false stall: ex_memRead=1, ex_writeReg=0, id_readReg1=0 -> no stall; id_useRs1=0 with matching reg 7 -> no stall.
- Taken branch coincident with load_use -> ifid_flush=idex_flush=1, pc_write=1, flush_cnt increments by 1, stall_cnt unchanged.
- mem_busy high 4 cycles with ex_branchTaken=1 held -> 4 cycles all writes 0, stall_cnt+4; release cycle performs the flush, flush_cnt+1.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt holds 15; assert rst during MEM_WAIT -> counters 0, state INIT immediately.
